// File: rtl/rflc_pipe_ctrl_pkg.sv
// Shared mode constants and the stalled-capacity helper for the micropipeline controller.
package rflc_pkg;

    localparam bit RFLC_4PHASE = 1'b1;
    localparam bit RFLC_2PHASE = 1'b0;

    // Tokens held with the consumer stalled: return-to-zero needs a bubble between tokens.
    function automatic int stalled_capacity(input int depth, input bit phase4);
        return phase4 ? (depth + 1) / 2 : depth;
    endfunction

endpackage

// File: rtl/rflc_pipe_ctrl_if.sv
// Producer/consumer handshake bundle; master drives requests/data/ack, slave is the pipe.
interface rflc_pipe_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Rin;
    logic [WIDTH-1:0] din;
    logic             Aout;
    logic             Rout;
    logic [WIDTH-1:0] dout;
    logic             Ain;

    modport master (
        output Rin, din, Ain,
        input  Aout, Rout, dout
    );

    modport slave (
        input  Rin, din, Ain,
        output Aout, Rout, dout
    );
endinterface

// File: rtl/rflc_pipe_ctrl_stage.sv
// One synchronous C-element stage with its bundled-data register; one edge per decision.
// Holds state whenever request and inverted ack disagree, which is the only backpressure.
module rflc_stage #(
    parameter int WIDTH  = 8,
    parameter bit PHASE4 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             lt_o,
    output logic [WIDTH-1:0] d_o
);

    logic             lt_q;
    logic             lt_d;
    logic             cap;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        lt_d = lt_q;
        if (req_i == ~ack_i) begin
            lt_d = req_i;
        end
        // Return-to-zero only carries data on the rising phase; transition mode on every change.
        cap    = PHASE4 ? (~lt_q & lt_d) : (lt_q ^ lt_d);
        data_d = cap ? d_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q   <= 1'b0;
            data_q <= '0;
        end else begin
            lt_q   <= lt_d;
            data_q <= data_d;
        end
    end

    assign lt_o = lt_q;
    assign d_o  = data_q;

endmodule

// File: rtl/rflc_pipe_ctrl.sv
// DEPTH-stage clocked micropipeline of C-element stages; Aout one edge after Rin, Rout DEPTH edges.
// Consumer stall backs tokens up stage by stage until the producer's Aout stops following Rin.
module rflc_pipe_ctrl
    import rflc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit PHASE4 = RFLC_4PHASE
) (
    input  logic                 clk,
    input  logic                 rst,
    rflc_pipe_ctrl_if.slave      bus,
    output logic [DEPTH-1:0]     lt
);

    logic [DEPTH-1:0] req_w;
    logic [DEPTH-1:0] ack_w;
    logic [DEPTH-1:0] lt_w;
    logic [WIDTH-1:0] din_w  [DEPTH];
    logic [WIDTH-1:0] data_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign req_w[i] = bus.Rin;
            assign din_w[i] = bus.din;
        end else begin : g_mid
            assign req_w[i] = lt_w[i-1];
            assign din_w[i] = data_w[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign ack_w[i] = bus.Ain;
        end else begin : g_body
            assign ack_w[i] = lt_w[i+1];
        end

        rflc_stage #(
            .WIDTH  (WIDTH),
            .PHASE4 (PHASE4)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .req_i (req_w[i]),
            .ack_i (ack_w[i]),
            .d_i   (din_w[i]),
            .lt_o  (lt_w[i]),
            .d_o   (data_w[i])
        );
    end

    assign bus.Aout = lt_w[0];
    assign bus.Rout = lt_w[DEPTH-1];
    assign bus.dout = data_w[DEPTH-1];
    assign lt       = lt_w;

endmodule

// File: tb/tb_rflc_pipe_ctrl.sv
// Bench for three pipe configurations: 4-phase DEPTH=3, 4-phase DEPTH=4, 2-phase DEPTH=4.
module tb_rflc_pipe_ctrl;
    import rflc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rin_v [3];
    logic       ain_v [3];
    logic [7:0] din_v [3];

    logic [2:0] lt0;
    logic [3:0] lt1;
    logic [3:0] lt2;

    int n_checks = 0;
    int n_pass   = 0;

    rflc_pipe_ctrl_if #(.WIDTH(8)) if0 ();
    rflc_pipe_ctrl_if #(.WIDTH(8)) if1 ();
    rflc_pipe_ctrl_if #(.WIDTH(8)) if2 ();

    assign if0.Rin = rin_v[0];
    assign if0.Ain = ain_v[0];
    assign if0.din = din_v[0];
    assign if1.Rin = rin_v[1];
    assign if1.Ain = ain_v[1];
    assign if1.din = din_v[1];
    assign if2.Rin = rin_v[2];
    assign if2.Ain = ain_v[2];
    assign if2.din = din_v[2];

    rflc_pipe_ctrl #(.WIDTH(8), .DEPTH(3), .PHASE4(RFLC_4PHASE)) dut0 (
        .clk (clk), .rst (rst), .bus (if0), .lt (lt0)
    );
    rflc_pipe_ctrl #(.WIDTH(8), .DEPTH(4), .PHASE4(RFLC_4PHASE)) dut1 (
        .clk (clk), .rst (rst), .bus (if1), .lt (lt1)
    );
    rflc_pipe_ctrl #(.WIDTH(8), .DEPTH(4), .PHASE4(RFLC_2PHASE)) dut2 (
        .clk (clk), .rst (rst), .bus (if2), .lt (lt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic get_out(input int s, output logic aout, output logic rout,
                           output logic [7:0] dout, output logic [3:0] ltv);
        case (s)
            0: begin aout = if0.Aout; rout = if0.Rout; dout = if0.dout; ltv = {1'b0, lt0}; end
            1: begin aout = if1.Aout; rout = if1.Rout; dout = if1.dout; ltv = lt1; end
            default: begin aout = if2.Aout; rout = if2.Rout; dout = if2.dout; ltv = lt2; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rin_v[k] = 1'b0;
            ain_v[k] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // which: 0 = Aout, 1 = Rout; returns as soon as the level is seen, within bound edges.
    task automatic wait_out(input int s, input int which, input logic val, input int bound,
                            output bit ok);
        logic a, r;
        logic [7:0] d;
        logic [3:0] l;
        ok = 1'b0;
        for (int k = 0; k <= bound; k++) begin
            get_out(s, a, r, d, l);
            if (((which == 0) ? a : r) == val) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic produce_4p(input int s, input logic [7:0] val, output bit ok);
        wait_out(s, 0, 1'b0, 20, ok);
        if (!ok) return;
        din_v[s] = val;
        rin_v[s] = 1'b1;
        wait_out(s, 0, 1'b1, 20, ok);
        rin_v[s] = 1'b0;
    endtask

    task automatic consume_4p(input int s, output logic [7:0] val, output bit ok);
        logic a, r;
        logic [3:0] l;
        bit ok2;
        val = 8'h00;
        wait_out(s, 1, 1'b1, 20, ok);
        if (!ok) return;
        get_out(s, a, r, val, l);
        ain_v[s] = 1'b1;
        wait_out(s, 1, 1'b0, 20, ok2);
        ain_v[s] = 1'b0;
        ok = ok & ok2;
    endtask

    task automatic produce_2p(input int s, input logic [7:0] val, output bit ok);
        wait_out(s, 0, rin_v[s], 20, ok);
        if (!ok) return;
        din_v[s] = val;
        rin_v[s] = ~rin_v[s];
        wait_out(s, 0, rin_v[s], 20, ok);
    endtask

    task automatic consume_2p(input int s, output logic [7:0] val, output bit ok);
        logic a, r;
        logic [3:0] l;
        val = 8'h00;
        wait_out(s, 1, ~ain_v[s], 20, ok);
        if (!ok) return;
        get_out(s, a, r, val, l);
        ain_v[s] = ~ain_v[s];
    endtask

    // Reference: the pipe is an order-preserving token queue; every request handshake
    // enqueues din, every consumer handshake must see the oldest outstanding value.
    task automatic stream(input int s, input bit p4, input int n);
        logic [7:0] q[$];
        int sent = 0, recv = 0, cyc = 0, pd = 0, cd = 0, extra = 0;
        logic aout, rout, ready;
        logic [7:0] dout, v;
        logic [3:0] ltv;
        while (recv < n && cyc < 20000) begin
            get_out(s, aout, rout, dout, ltv);
            if (p4) begin
                if (!rin_v[s] && !aout && sent < n) begin
                    if (pd == 0) begin
                        v = 8'($urandom);
                        din_v[s] = v;
                        rin_v[s] = 1'b1;
                        q.push_back(v);
                        sent++;
                        pd = int'($urandom_range(0, 3));
                    end else begin
                        pd--;
                    end
                end else if (rin_v[s] && aout) begin
                    rin_v[s] = 1'b0;
                end
            end else if (aout == rin_v[s] && sent < n) begin
                if (pd == 0) begin
                    v = 8'($urandom);
                    din_v[s] = v;
                    rin_v[s] = ~rin_v[s];
                    q.push_back(v);
                    sent++;
                    pd = int'($urandom_range(0, 3));
                end else begin
                    pd--;
                end
            end
            ready = p4 ? (rout && !ain_v[s]) : (rout != ain_v[s]);
            if (ready) begin
                if (cd == 0) begin
                    if (q.size() == 0) begin
                        chk("stream_underrun", 32'(q.size()), 32'd1);
                    end else begin
                        chk("stream_data", 32'(dout), 32'(q.pop_front()));
                    end
                    recv++;
                    ain_v[s] = p4 ? 1'b1 : rout;
                    cd = int'($urandom_range(0, 5));
                end else begin
                    cd--;
                end
            end else if (p4 && !rout && ain_v[s]) begin
                ain_v[s] = 1'b0;
            end
            step();
            cyc++;
        end
        chk("stream_count", 32'(recv), 32'(n));
        for (int k = 0; k < 20; k++) begin
            get_out(s, aout, rout, dout, ltv);
            if (p4 && rin_v[s] && aout) rin_v[s] = 1'b0;
            if (p4 && !rout && ain_v[s]) ain_v[s] = 1'b0;
            ready = p4 ? (rout && !ain_v[s]) : (rout != ain_v[s]);
            if (ready) extra++;
            step();
        end
        get_out(s, aout, rout, dout, ltv);
        chk("stream_extra", 32'(extra), 32'd0);
        chk("stream_qempty", 32'(q.size()), 32'd0);
        chk("stream_idle_lt", 32'(ltv), 32'({4{rin_v[s]}}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, r;
        logic [7:0] d, v;
        logic [3:0] l;
        bit ok;
        int acc;
        logic [7:0] tv [4];
        tv[0] = 8'h11; tv[1] = 8'h22; tv[2] = 8'h33; tv[3] = 8'h44;

        // Reset dominates even with both requests asserted.
        for (int k = 0; k < 3; k++) begin
            rin_v[k] = 1'b1;
            ain_v[k] = 1'b1;
            din_v[k] = 8'hFF;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            for (int s = 0; s < 3; s++) begin
                get_out(s, a, r, d, l);
                chk("rst_lt", 32'(l), 32'd0);
                chk("rst_aout", 32'(a), 32'd0);
                chk("rst_rout", 32'(r), 32'd0);
                chk("rst_dout", 32'(d), 32'd0);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rin_v[k] = 1'b0;
            ain_v[k] = 1'b0;
        end
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            get_out(s, a, r, d, l);
            chk("idle_lt", 32'(l), 32'd0);
            chk("idle_dout", 32'(d), 32'd0);
        end

        // 4-phase single token, DEPTH=3: lt fills 001, 011, 111.
        din_v[0] = 8'hA5;
        rin_v[0] = 1'b1;
        step();
        get_out(0, a, r, d, l);
        chk("tok_lt1", 32'(l), 32'b001);
        chk("tok_aout1", 32'(a), 32'd1);
        step();
        get_out(0, a, r, d, l);
        chk("tok_lt2", 32'(l), 32'b011);
        chk("tok_rout2", 32'(r), 32'd0);
        step();
        get_out(0, a, r, d, l);
        chk("tok_lt3", 32'(l), 32'b111);
        chk("tok_rout3", 32'(r), 32'd1);
        chk("tok_dout3", 32'(d), 32'hA5);

        // 4-phase stall, DEPTH=3: two tokens fit, third is refused.
        do_reset();
        acc = 0;
        produce_4p(0, 8'hA5, ok);
        acc += int'(ok);
        produce_4p(0, 8'h3C, ok);
        acc += int'(ok);
        produce_4p(0, 8'h5A, ok);
        acc += int'(ok);
        chk("stall4_cap", 32'(acc), 32'(stalled_capacity(3, RFLC_4PHASE)));
        repeat (6) step();
        get_out(0, a, r, d, l);
        chk("stall4_lt", 32'(l), 32'b101);
        chk("stall4_aout", 32'(a), 32'd1);
        chk("stall4_dout", 32'(d), 32'hA5);

        consume_4p(0, v, ok);
        chk("drain4_ok0", 32'(ok), 32'd1);
        chk("drain4_v0", 32'(v), 32'hA5);
        consume_4p(0, v, ok);
        chk("drain4_ok1", 32'(ok), 32'd1);
        chk("drain4_v1", 32'(v), 32'h3C);
        repeat (6) step();
        get_out(0, a, r, d, l);
        chk("drain4_lt", 32'(l), 32'b000);

        // 2-phase stall, DEPTH=4: all four tokens held.
        do_reset();
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            produce_2p(2, tv[k], ok);
            acc += int'(ok);
        end
        chk("stall2_cap", 32'(acc), 32'(stalled_capacity(4, RFLC_2PHASE)));
        repeat (6) step();
        get_out(2, a, r, d, l);
        chk("stall2_lt", 32'(l), 32'b1010);
        chk("stall2_dout", 32'(d), 32'h11);
        chk("stall2_aout", 32'(a), 32'(rin_v[2]));
        for (int k = 0; k < 4; k++) begin
            consume_2p(2, v, ok);
            chk("drain2_ok", 32'(ok), 32'd1);
            chk("drain2_v", 32'(v), 32'(tv[k]));
        end

        // Streaming with random producer/consumer pacing.
        do_reset();
        stream(1, 1'b1, 200);
        do_reset();
        stream(2, 1'b0, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
